// File: rtl/key_bounce_gen.sv
// key_bounce_gen
//   Emulates a mechanical push-button on an active-low key line. A single
//   start request produces one press / hold / release sequence. Each of the
//   press and release transitions carries BOUNCE_CNT glitches. Bounce
//   intervals are BOUNCE_MIN plus an optional pseudo-random jitter, taken from
//   an 8-bit LFSR masked by BOUNCE_MASK.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   start     one-cycle request; ignored unless idle (and not in the done cycle)
//   hold_len  stable-low hold time in cycles, sampled with start (0 acts as 1)
//   key       emulated key line, 1 = released, 0 = pressed
//   busy      sequence in progress
//   done      one-cycle pulse at the end of a sequence
//
// States
//   IDLE  | key released, waiting for start
//   P_BNC | press bounce, toggling key at each interval expiry
//   HOLD  | key held low for the latched hold length
//   R_BNC | release bounce, toggling key at each interval expiry
//   TAIL  | final settle interval before done
module key_bounce_gen #(
  parameter int unsigned BOUNCE_CNT  = 4,
  parameter int unsigned BOUNCE_MIN  = 10,
  parameter logic [7:0]  BOUNCE_MASK = 8'h00,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] hold_len,
  output logic        key,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] EDGES    = 16'(2 * BOUNCE_CNT);
  localparam logic [15:0] IVL_BASE = 16'(BOUNCE_MIN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P_BNC = 3'd1,
    HOLD  = 3'd2,
    R_BNC = 3'd3,
    TAIL  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        key_q, key_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] edge_q, edge_d;
  logic [15:0] ivl_q, ivl_d;
  logic [23:0] hold_q, hold_d;
  logic [23:0] hcnt_q, hcnt_d;

  logic [15:0] ivl_new;
  logic [7:0]  lfsr_next;
  logic [23:0] hold_in;
  logic        ivl_exp;
  logic        hcnt_exp;
  logic        load_ivl;

  assign ivl_new   = IVL_BASE + {8'h00, lfsr_q & BOUNCE_MASK};
  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign hold_in   = (hold_len == 24'd0) ? 24'd1 : hold_len;
  // A counter loaded with L expires L edges after the load.
  assign ivl_exp   = (ivl_q == 16'd1);
  assign hcnt_exp  = (hcnt_q == 24'd1);

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    edge_d   = edge_q;
    hold_d   = hold_q;
    ivl_d    = (ivl_q != 16'd0) ? ivl_q - 16'd1 : 16'd0;
    hcnt_d   = (hcnt_q != 24'd0) ? hcnt_q - 24'd1 : 24'd0;
    load_ivl = 1'b0;

    case (state_q)
      IDLE: begin
        key_d  = 1'b1;
        busy_d = 1'b0;
        // done_q high means this is the done cycle: the request is dropped.
        if (start && !done_q) begin
          hold_d = hold_in;
          key_d  = 1'b0;
          busy_d = 1'b1;
          if (EDGES == 16'd0) begin
            state_d = HOLD;
            hcnt_d  = hold_in;
          end else begin
            state_d  = P_BNC;
            edge_d   = EDGES;
            load_ivl = 1'b1;
          end
        end
      end
      P_BNC: begin
        if (ivl_exp) begin
          key_d  = ~key_q;
          edge_d = edge_q - 16'd1;
          // The last press edge starts the hold directly, so the hold is
          // measured from the final fall.
          if (edge_q == 16'd1) begin
            state_d = HOLD;
            hcnt_d  = hold_q;
          end else begin
            load_ivl = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hcnt_exp) begin
          key_d    = 1'b1;
          load_ivl = 1'b1;
          if (EDGES == 16'd0) begin
            state_d = TAIL;
          end else begin
            state_d = R_BNC;
            edge_d  = EDGES;
          end
        end
      end
      R_BNC: begin
        if (ivl_exp) begin
          key_d    = ~key_q;
          edge_d   = edge_q - 16'd1;
          load_ivl = 1'b1;
          if (edge_q == 16'd1) begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        if (ivl_exp) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_ivl) begin
      ivl_d = ivl_new;
    end
    lfsr_d = load_ivl ? lfsr_next : lfsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      edge_q  <= 16'd0;
      ivl_q   <= 16'd0;
      hold_q  <= 24'd0;
      hcnt_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lfsr_q  <= lfsr_d;
      edge_q  <= edge_d;
      ivl_q   <= ivl_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign key  = key_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen. Three instances with different parameters share
// clock and reset. A reference model turns each accepted start into a list of
// key edge times and a done time, and every cycle all outputs are compared
// with it. Cycle c means the values visible after clock edge c; a start
// presented in cycle c is taken as relative cycle 0.
module tb_key_bounce_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = 3'b000;
  logic [23:0] hold_len [3];
  logic [2:0]  key, busy, done;

  always #5 clk = ~clk;

  key_bounce_gen #(.BOUNCE_CNT(2), .BOUNCE_MIN(10), .BOUNCE_MASK(8'h00), .LFSR_SEED(8'hA5)) u_fix (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .hold_len(hold_len[0]),
    .key(key[0]), .busy(busy[0]), .done(done[0]));

  key_bounce_gen #(.BOUNCE_CNT(0), .BOUNCE_MIN(5), .BOUNCE_MASK(8'h00), .LFSR_SEED(8'hA5)) u_n0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .hold_len(hold_len[1]),
    .key(key[1]), .busy(busy[1]), .done(done[1]));

  key_bounce_gen #(.BOUNCE_CNT(3), .BOUNCE_MIN(4), .BOUNCE_MASK(8'h07), .LFSR_SEED(8'hA5)) u_rnd (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .hold_len(hold_len[2]),
    .key(key[2]), .busy(busy[2]), .done(done[2]));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  bit         act [3];
  int         t0 [3];
  int         dt [3];
  int         ev [3][32];
  int         nev [3];
  logic [7:0] mlfsr [3];

  bit   rec_on = 1'b0;
  logic prev_k2 = 1'b1;
  int   obs[$];
  int   obs1[$];

  function automatic int n_of(input int i);
    case (i)
      0: return 2;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int b_of(input int i);
    case (i)
      0: return 10;
      1: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic int m_of(input int i);
    return (i == 2) ? 7 : 0;
  endfunction

  function automatic int rh();
    return int'($urandom_range(0, 30));
  endfunction

  // Interval from the current LFSR value, then one LFSR step (taps 8,6,5,4).
  function automatic int next_ivl(input int i);
    int v;
    v = b_of(i) + int'(mlfsr[i] & 8'(m_of(i)));
    mlfsr[i] = {mlfsr[i][6:0], ^(mlfsr[i] & 8'hB8)};
    return v;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_start(input int i, input int h);
    int hh;
    int t;
    hh = (h == 0) ? 1 : h;
    t = 1;
    nev[i] = 0;
    ev[i][nev[i]] = t; nev[i]++;
    for (int k = 0; k < 2 * n_of(i); k++) begin
      t = t + next_ivl(i);
      ev[i][nev[i]] = t; nev[i]++;
    end
    t = t + hh;
    ev[i][nev[i]] = t; nev[i]++;
    for (int k = 0; k < 2 * n_of(i); k++) begin
      t = t + next_ivl(i);
      ev[i][nev[i]] = t; nev[i]++;
    end
    dt[i] = t + next_ivl(i);
    t0[i] = cyc;
    act[i] = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0;
      mlfsr[i] = 8'hA5;
    end
    prev_k2 = 1'b1;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int ek;
      int eb;
      int ed;
      ek = 1; eb = 0; ed = 0;
      if (act[i] && (cyc - t0[i]) <= dt[i]) begin
        int rel;
        int cnt;
        rel = cyc - t0[i];
        cnt = 0;
        for (int j = 0; j < nev[i]; j++) if (ev[i][j] <= rel) cnt++;
        ek = (cnt % 2 == 0) ? 1 : 0;
        eb = (rel >= 1) ? 1 : 0;
        ed = (rel == dt[i]) ? 1 : 0;
      end
      check_eq($sformatf("key%0d", i), int'(key[i]), ek);
      check_eq($sformatf("busy%0d", i), int'(busy[i]), eb);
      check_eq($sformatf("done%0d", i), int'(done[i]), ed);
    end
    if (rec_on && (key[2] !== prev_k2 || done[2] === 1'b1)) obs.push_back(cyc);
    prev_k2 = key[2];
  endtask

  task automatic step(input logic [2:0] st, input int h0, input int h1, input int h2);
    @(posedge clk);
    cyc++;
    #1;
    start = st;
    hold_len[0] = 24'(h0);
    hold_len[1] = 24'(h1);
    hold_len[2] = 24'(h2);
    for (int i = 0; i < 3; i++) begin
      if (st[i] && rst_n && (!act[i] || (cyc - t0[i]) > dt[i]))
        model_start(i, (i == 0) ? h0 : (i == 1) ? h1 : h2);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic release_reset();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    start = 3'b000;
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_key%0d", i), int'(key[i]), 1);
      check_eq($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
      check_eq($sformatf("rst_done%0d", i), int'(done[i]), 0);
    end
    model_reset();
    for (int k = 0; k < 3; k++) step(3'($urandom), rh(), rh(), rh());
    release_reset();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hold_len[i] = 24'd0;
    model_reset();

    // Held in reset while start toggles.
    for (int k = 0; k < 6; k++) step(3'($urandom), rh(), rh(), rh());
    release_reset();

    // Fixed bounce N=2, B=10, hold 100; starts at 50 and at done are dropped,
    // start at done+1 is taken.
    for (int r = 0; r <= 340; r++) begin
      logic [2:0] st;
      st = 3'b000;
      st[0] = (r == 0 || r == 50 || r == 191 || r == 192);
      step(st, (r == 0) ? 100 : (r == 192) ? 37 : int'($urandom_range(0, 200)), rh(), rh());
      if (r == 1)   check_eq("fix_first_fall", int'(key[0]), 0);
      if (r == 11)  check_eq("fix_rise_11", int'(key[0]), 1);
      if (r == 41)  check_eq("fix_final_low", int'(key[0]), 0);
      if (r == 141) check_eq("fix_release_rise", int'(key[0]), 1);
      if (r == 171) check_eq("fix_fall_171", int'(key[0]), 0);
      if (r == 181) check_eq("fix_final_high", int'(key[0]), 1);
      if (r == 190) check_eq("fix_no_early_done", int'(done[0]), 0);
      if (r == 191) check_eq("fix_done", int'(done[0]), 1);
      if (r == 192) check_eq("fix_busy_drop", int'(busy[0]), 0);
      if (r == 193) check_eq("fix_restart_fall", int'(key[0]), 0);
    end

    // N=0, B=5, hold_len 0.
    for (int r = 0; r <= 12; r++) begin
      step({1'b0, (r == 0), 1'b0}, rh(), 0, rh());
      if (r == 1) check_eq("n0_fall", int'(key[1]), 0);
      if (r == 2) check_eq("n0_rise", int'(key[1]), 1);
      if (r == 6) check_eq("n0_no_early_done", int'(done[1]), 0);
      if (r == 7) check_eq("n0_done", int'(done[1]), 1);
    end

    // Masked jitter: two runs from reset must give the same interval pattern.
    for (int run = 0; run < 2; run++) begin
      async_reset();
      obs.delete();
      rec_on = 1'b1;
      for (int r = 0; r <= 180; r++) step({(r == 0), 2'b00}, rh(), rh(), 20);
      rec_on = 1'b0;
      if (run == 0) obs1 = obs;
    end
    check_eq("rnd_event_count", obs.size(), 15);
    check_eq("rnd_repeat_len", obs.size(), obs1.size());
    for (int j = 0; j < obs.size() && j < obs1.size(); j++)
      check_eq("rnd_repeat", obs[j] - obs[0], obs1[j] - obs1[0]);
    for (int j = 0; j + 1 < obs.size(); j++) begin
      int g;
      g = obs[j + 1] - obs[j];
      if (j != 6) check_eq("rnd_ivl_range", (g >= 4 && g <= 11) ? 1 : 0, 1);
    end

    // Reset in the middle of the hold.
    async_reset();
    for (int r = 0; r <= 80; r++) step({2'b00, (r == 0)}, 100, rh(), rh());
    check_eq("fix_in_hold", int'(key[0]), 0);
    async_reset();

    // Random traffic on all three instances.
    for (int k = 0; k < 3000; k++) begin
      logic [2:0] st;
      for (int i = 0; i < 3; i++) st[i] = ($urandom_range(0, 15) == 0);
      step(st, rh(), rh(), rh());
    end
    for (int k = 0; k < 200; k++) step(3'b000, rh(), rh(), rh());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_bounce_gen.md
# key_bounce_gen

Synthesizable mechanical-key emulator that drives an active-low key line with deterministic, programmable contact bounce on both press and release. It is the transmitting end of the key/debounce path: it sits in front of `key_edge` in hardware-in-the-loop and self-test builds, replacing the physical button. It lets the debouncer be exercised on silicon with repeatable press/hold/release sequences.

## Interface
- `BOUNCE_CNT`, 4: number of glitches per transition; each glitch is 2 edges.
- `BOUNCE_MIN`, 10: minimum cycles between bounce edges; must be ≥1.
- `BOUNCE_MASK`, 8'h00: AND-mask applied to the LFSR and added to the interval. A value of 0 gives fixed intervals.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be non-zero.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request for one press/hold/release sequence.
- `hold_len` in 24: stable-low hold time in cycles, sampled with `start`. A value of 0 is treated as 1.
- `key` out 1: emulated key line; 1 = released, 0 = pressed.
- `busy` out 1: sequence in progress.
- `done` out 1: single-cycle pulse at end of sequence.

## Operation
- States:
  - IDLE: `key`=1, `busy`=0.
  - P_BNC: press bounce.
  - HOLD: stable low.
  - R_BNC: release bounce.
  - TAIL: final settle interval.
- IDLE → P_BNC on `start`=1.
  - Latch `hold_len` (0→1).
  - `key`←0 and `busy`←1 on the next clock edge.
  - Load edge counter with 2·`BOUNCE_CNT` and interval counter with I.
- Interval I = `BOUNCE_MIN` + (lfsr & `BOUNCE_MASK`).
  - The LFSR (8-bit Fibonacci, taps 8,6,5,4) advances exactly once each time I is loaded.
  - Interval counter is 16 bits; parameters must keep I ≤ 65535.
- P_BNC:
  - When the interval expires with edges remaining: toggle `key`, decrement the edge count, reload I.
  - When the edge count is 0: go to HOLD with the hold counter = latched length; `key` stays 0.
- HOLD:
  - Count down.
  - At expiry: `key`←1, go to R_BNC with edge count 2·`BOUNCE_CNT`, reload I.
- R_BNC:
  - Same toggle rule as P_BNC. The final edge always leaves `key`=1.
  - At edge count 0: reload I and go to TAIL.
- TAIL:
  - On expiry, assert `done` for 1 cycle and return to IDLE.
  - `busy` deasserts on the cycle after `done`.
- `BOUNCE_CNT`=0: no glitches. P_BNC and R_BNC pass straight through, with one clean fall and one clean rise.
- `start` while `busy`=1 is ignored, with no queuing. `start` in the same cycle `done` is high is also ignored. A new start is accepted from the first IDLE cycle.
- `hold_len` changes while busy have no effect.
- LFSR state persists across sequences and is reseeded only by reset.

## Timing
- Reset values: `key`=1, `busy`=0, `done`=0, state IDLE, lfsr=`LFSR_SEED`, all counters 0. Reset applies immediately mid-sequence.
- Notation: cycle 0 = clock edge sampling `start`. With `BOUNCE_MASK`=0, B=`BOUNCE_MIN`, N=`BOUNCE_CNT`, H=latched hold length.
- Press bounce:
  - First fall at cycle 1.
  - Press edges at 1+k·B, k=0..2N.
  - Final low at 1+2NB.
- Release bounce:
  - Release rise at 1+2NB+H.
  - Release edges every B after that; final high at 1+4NB+H.
- `done` at 1+(4N+1)B+H. `busy`=1 from cycle 1 through the `done` cycle inclusive.
- All outputs are registered, with no combinational path from inputs.
- `key` is glitch-free per clock and changes at most once per cycle.

## Test plan
- Reset: hold `rst_n`=0, toggle `start` → `key`=1, `busy`=0, `done`=0 throughout.
- Fixed bounce (N=2, B=10, MASK=0), `start` with `hold_len`=100 at cycle 0:
  - Falls at cycles 1/21/41 and rises at 11/31.
  - Rises at 141/161/181 and falls at 151/171.
  - `done` only at 191, `busy` low at 192.
  - `key_edge` downstream produces exactly one `key_come`.
- N=0, B=5, `hold_len`=0 → `key` low at cycle 1, high at cycle 2, `done` at 7.
- `start` pulses at cycles 50 and at the `done` cycle during the fixed-bounce run → ignored. A `start` at `done`+1 launches a new sequence with first fall one cycle later.
- Reset mid-HOLD (`rst_n` low at cycle 80 of the fixed-bounce run) → `key`=1 and `busy`=0 asynchronously. After release, the first sequence reproduces the power-up interval sequence.
- MASK=8'h07, seed 8'hA5 → every bounce interval lies in [B, B+7]. The interval sequence matches the LFSR reference model and is identical across two runs from reset.
